clic_irq_scanner: RTL
=====================

Name: clic_irq_scanner

Overview:
- Sequential CLIC arbiter for the core's 256-source Sclic interrupt controller.
- Sweeps the pending/enable/level state SRC_PER_CYCLE sources per cycle and finds the highest-level eligible interrupt.
- Presents that interrupt to the core's interrupt-entry logic over a valid/ready handshake, then restarts the sweep.
- Replaces a full 256-input combinational max tree with a time-multiplexed one, for timing.

Parameters:
- NUM_SRC, 256, number of interrupt sources.
- SRC_PER_CYCLE, 8, sources examined per scan cycle; NUM_SRC need not be a multiple of it.
- LVL_W, 8, interrupt level width.
- ID_W, $clog2(NUM_SRC), source ID width (derived, not overridable).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  scanner enable (mstatus.MIE-qualified global enable)
- pending_i  in  NUM_SRC  per-source pending bit
- enable_i  in  NUM_SRC  per-source enable bit
- level_i  in  NUM_SRC*LVL_W  per-source level; source k occupies bits [k*LVL_W +: LVL_W]
- thresh_i  in  LVL_W  current interrupt threshold (max of mintthresh and current level)
- irq_valid_o  out  1  candidate interrupt presented
- irq_id_o  out  ID_W  candidate source ID
- irq_level_o  out  LVL_W  candidate level
- irq_ready_i  in  1  core accepts the candidate
- claim_o  out  1  one-cycle pulse on accept
- claim_id_o  out  ID_W  ID accepted; valid while claim_o=1
- sweep_done_o  out  1  one-cycle pulse at the end of every complete sweep

Behaviour:
- Reset: all outputs 0; state IDLE; chunk index 0; best_valid 0.
- Chunks: NCHUNK = ceil(NUM_SRC/SRC_PER_CYCLE); default 32.
- Eligibility: source k is eligible iff pending_i[k] & enable_i[k] & (level > thresh_i), unsigned compare.
  - Sources >= NUM_SRC in the last partial chunk are forced ineligible.
- FSM states: IDLE, SCAN, PRESENT.
- IDLE:
  - irq_valid_o=0.
  - If en_i=1: go to SCAN next cycle; idx=0; best cleared.
- SCAN:
  - Each cycle, evaluate chunk idx.
  - Within the chunk, pick the highest level; ties go to the lowest ID.
  - Update best when the chunk winner level > best_level (strict compare), or when best_valid=0.
  - Net effect: global ties resolve to the lowest ID.
  - idx increments by 1 per cycle.
  - On the last chunk, assert sweep_done_o for that cycle, then:
    - best found (including the last chunk's contribution): go to PRESENT; irq_id_o and irq_level_o registered.
    - none found and en_i=1: idx=0; best cleared; continue SCAN (back-to-back sweeps, no bubble).
    - none found and en_i=0: go to IDLE.
  - en_i=0 on any SCAN cycle: go to IDLE next cycle; partial result discarded.
- PRESENT:
  - irq_valid_o=1; irq_id_o and irq_level_o held stable.
  - irq_ready_i=1 (with valid): next cycle claim_o=1 and claim_id_o=irq_id_o; irq_valid_o=0; state SCAN; idx=0; best cleared.
  - Revocation: presented source stops being eligible (pending, enable or threshold change, sampled each cycle), or en_i=0:
    - irq_valid_o drops next cycle; no claim.
    - Next state is SCAN if en_i=1, else IDLE.
  - Ready and revocation in the same cycle: the ready wins; claim is issued.
  - No preemption in PRESENT: a higher-level arrival is picked up only by the next sweep.
- Latency:
  - From the first SCAN cycle to irq_valid_o=1 is NCHUNK+1 cycles (33 at defaults).
  - Eligibility changes after a chunk was sampled are seen only on the next sweep.
- Reset asserted in any state: next cycle matches the reset values; no claim_o is emitted.
- claim_o and sweep_done_o are never asserted for more than one consecutive cycle per event.

Optional Feature:
- Macro CLIC_SCAN_EARLY_EXIT_EN.
- Defined: in SCAN, if the updated best level equals all-ones (2^LVL_W-1), terminate the sweep that cycle.
  - Go to PRESENT next cycle; sweep_done_o is not pulsed for a truncated sweep.
  - The lowest-ID max-level source wins; no higher level is possible.
- Undefined: every sweep runs all NCHUNK chunks; latency is fixed at NCHUNK+1.

Test Plan:
- Reset then en_i=1, source 37 pending+enabled with level 0x40, thresh 0x00 -> irq_valid_o=1 after 33 cycles; id 37, level 0x40; sweep_done_o pulses once, in the cycle before valid.
- Sources 10 and 200 both level 0x80, source 5 level 0x7F -> id 10 presented; assert ready -> claim_o pulse with claim_id_o=10; new sweep starts at idx 0.
- Source 100 level 0x20, thresh 0x20 -> no valid ever; sweep_done_o every 32 cycles; drop en_i mid-sweep -> IDLE next cycle, outputs 0.
- PRESENT with id 100 level 0x30, clear pending_i[100] -> irq_valid_o=0 next cycle, no claim_o; rescan. Repeat with ready and pending drop in the same cycle -> claim_o=1, id 100.
- NUM_SRC=250, SRC_PER_CYCLE=8, source 249 level 0x10 -> NCHUNK=32; id 249 presented; out-of-range slots 250..255 ignored.
- Build with CLIC_SCAN_EARLY_EXIT_EN, source 3 level 0xFF -> valid 2 cycles after SCAN entry, id 3. Build without the macro -> valid after 33 cycles.

Source files
------------

// File: rtl/clic_irq_scanner.sv
// Sequential CLIC arbiter: sweeps SRC_PER_CYCLE sources per cycle and presents the highest-level eligible IRQ.
// Optional build macro CLIC_SCAN_EARLY_EXIT_EN ends a sweep as soon as a max-level source is found.
module clic_irq_scanner #(
    parameter  int NUM_SRC       = 256,
    parameter  int SRC_PER_CYCLE = 8,
    parameter  int LVL_W         = 8,
    localparam int ID_W          = $clog2(NUM_SRC)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [NUM_SRC-1:0]       pending_i,
    input  logic [NUM_SRC-1:0]       enable_i,
    input  logic [NUM_SRC*LVL_W-1:0] level_i,
    input  logic [LVL_W-1:0]         thresh_i,
    output logic                     irq_valid_o,
    output logic [ID_W-1:0]          irq_id_o,
    output logic [LVL_W-1:0]         irq_level_o,
    input  logic                     irq_ready_i,
    output logic                     claim_o,
    output logic [ID_W-1:0]          claim_id_o,
    output logic                     sweep_done_o
);
    localparam int NCHUNK = (NUM_SRC + SRC_PER_CYCLE - 1) / SRC_PER_CYCLE;
    localparam int NPAD   = NCHUNK * SRC_PER_CYCLE;
    localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int K_W    = $clog2(NPAD) + 1;
    localparam logic [CIDX_W-1:0] LAST_IDX  = CIDX_W'(NCHUNK - 1);
    localparam logic [K_W-1:0]    NUM_SRC_K = K_W'(NUM_SRC);
    localparam logic [LVL_W-1:0]  LVL_MAX   = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_PRESENT} state_t;

    logic [LVL_W-1:0] lvl_arr [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lvl
        assign lvl_arr[g] = level_i[g*LVL_W +: LVL_W];
    end

    state_t            state_p1, state_d;
    logic [CIDX_W-1:0] idx_p1, idx_d;
    logic              best_vld_p1, best_vld_d;
    logic [ID_W-1:0]   best_id_p1, best_id_d;
    logic [LVL_W-1:0]  best_lvl_p1, best_lvl_d;
    logic [ID_W-1:0]   irq_id_p2, irq_id_d;
    logic [LVL_W-1:0]  irq_lvl_p2, irq_lvl_d;
    logic              claim_p2, claim_d;
    logic [ID_W-1:0]   claim_id_p2, claim_id_d;

    logic              chunk_vld_p0;
    logic [ID_W-1:0]   chunk_id_p0;
    logic [LVL_W-1:0]  chunk_lvl_p0;
    logic [K_W-1:0]    k;
    logic [ID_W-1:0]   kk;
    logic              elig;

    // Stage p0: winner of the current chunk; strict compare in ascending order keeps the lowest ID on ties
    always_comb begin
        chunk_vld_p0 = 1'b0;
        chunk_id_p0  = '0;
        chunk_lvl_p0 = '0;
        k            = '0;
        kk           = '0;
        elig         = 1'b0;
        for (int j = 0; j < SRC_PER_CYCLE; j++) begin
            k    = K_W'(idx_p1) * K_W'(SRC_PER_CYCLE) + K_W'(j);
            kk   = k[ID_W-1:0];
            elig = (k < NUM_SRC_K) && pending_i[kk] && enable_i[kk] && (lvl_arr[kk] > thresh_i);
            if (elig && (!chunk_vld_p0 || lvl_arr[kk] > chunk_lvl_p0)) begin
                chunk_vld_p0 = 1'b1;
                chunk_id_p0  = kk;
                chunk_lvl_p0 = lvl_arr[kk];
            end
        end
    end

    logic             take_chunk, new_vld, early_exit, pres_elig;
    logic [ID_W-1:0]  new_id;
    logic [LVL_W-1:0] new_lvl;

    always_comb begin
        take_chunk = chunk_vld_p0 && (!best_vld_p1 || chunk_lvl_p0 > best_lvl_p1);
        new_vld    = best_vld_p1 || chunk_vld_p0;
        new_id     = take_chunk ? chunk_id_p0  : best_id_p1;
        new_lvl    = take_chunk ? chunk_lvl_p0 : best_lvl_p1;
`ifdef CLIC_SCAN_EARLY_EXIT_EN
        early_exit = new_vld && (new_lvl == LVL_MAX);
`else
        early_exit = 1'b0;
`endif
        pres_elig  = pending_i[irq_id_p2] && enable_i[irq_id_p2] && (lvl_arr[irq_id_p2] > thresh_i);
    end

    always_comb begin
        state_d    = state_p1;
        idx_d      = idx_p1;
        best_vld_d = best_vld_p1;
        best_id_d  = best_id_p1;
        best_lvl_d = best_lvl_p1;
        irq_id_d   = irq_id_p2;
        irq_lvl_d  = irq_lvl_p2;
        claim_d    = 1'b0;
        claim_id_d = '0;
        unique case (state_p1)
            ST_IDLE: begin
                if (en_i) begin
                    state_d    = ST_SCAN;
                    idx_d      = '0;
                    best_vld_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (!en_i) begin
                    state_d    = ST_IDLE;
                    idx_d      = '0;
                    best_vld_d = 1'b0;
                end else if (early_exit || (idx_p1 == LAST_IDX && new_vld)) begin
                    state_d    = ST_PRESENT;
                    irq_id_d   = new_id;
                    irq_lvl_d  = new_lvl;
                    best_vld_d = 1'b0;
                end else if (idx_p1 == LAST_IDX) begin
                    idx_d      = '0;
                    best_vld_d = 1'b0;
                end else begin
                    idx_d      = idx_p1 + CIDX_W'(1);
                    best_vld_d = new_vld;
                    best_id_d  = new_id;
                    best_lvl_d = new_lvl;
                end
            end
            ST_PRESENT: begin
                // Ready beats a same-cycle revocation; no preemption while presenting
                if (irq_ready_i || !pres_elig || !en_i) begin
                    state_d    = (irq_ready_i || en_i) ? ST_SCAN : ST_IDLE;
                    idx_d      = '0;
                    best_vld_d = 1'b0;
                    irq_id_d   = '0;
                    irq_lvl_d  = '0;
                    claim_d    = irq_ready_i;
                    claim_id_d = irq_ready_i ? irq_id_p2 : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p1/p2: sweep state and presented candidate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p1    <= ST_IDLE;
            idx_p1      <= '0;
            best_vld_p1 <= 1'b0;
            irq_id_p2   <= '0;
            irq_lvl_p2  <= '0;
            claim_p2    <= 1'b0;
            claim_id_p2 <= '0;
        end else begin
            state_p1    <= state_d;
            idx_p1      <= idx_d;
            best_vld_p1 <= best_vld_d;
            irq_id_p2   <= irq_id_d;
            irq_lvl_p2  <= irq_lvl_d;
            claim_p2    <= claim_d;
            claim_id_p2 <= claim_id_d;
        end
        best_id_p1  <= best_id_d;
        best_lvl_p1 <= best_lvl_d;
    end

    assign irq_valid_o  = (state_p1 == ST_PRESENT);
    assign irq_id_o     = irq_id_p2;
    assign irq_level_o  = irq_lvl_p2;
    assign claim_o      = claim_p2;
    assign claim_id_o   = claim_id_p2;
    assign sweep_done_o = (state_p1 == ST_SCAN) && (idx_p1 == LAST_IDX);

endmodule
